// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus between the CPU memory controller and ram_io_responder,
// bundled with the TX drain handshake toward the downstream UART transmitter.
// Optional macro IO_OVERFLOW_EN adds the sticky io_overflow status line.
interface ram_io_responder_if;
    logic        rdy;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
`ifdef IO_OVERFLOW_EN
    logic        io_overflow;
`endif

    // Controller / UART side: drives addresses, write data and the drain ready.
    modport master (
        output rdy, mem_addr, mem_wr, mem_din, tx_ready,
        input  mem_dout, io_buffer_full, tx_data, tx_valid, halt
`ifdef IO_OVERFLOW_EN
        , input io_overflow
`endif
    );

    // Responder side: services RAM/I-O accesses and sources the TX stream.
    modport slave (
        input  rdy, mem_addr, mem_wr, mem_din, tx_ready,
        output mem_dout, io_buffer_full, tx_data, tx_valid, halt
`ifdef IO_OVERFLOW_EN
        , output io_overflow
`endif
    );
endinterface

// File: rtl/ram_io_responder.sv
// Memory-side responder for the byte-serial CPU bus: a 2^ADDR_WIDTH-byte RAM,
// a small I/O region (TX FIFO push / FIFO count / halt), and a valid/ready
// drain of the TX FIFO toward a UART transmitter.
// Optional macro IO_OVERFLOW_EN adds a sticky overflow flag at 0x30008.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] NEAR_FULL_C = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
    localparam logic [17:0] IO_STAT_ADDR = 18'h30004;
    localparam logic [17:0] IO_OVF_ADDR  = 18'h30008;

    logic [7:0] ram [2**ADDR_WIDTH];
    logic [7:0] fifo_buf [FIFO_DEPTH];

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [7:0]            mem_dout_q;
    logic [7:0]            rd_data;
    logic                  halt_q;

    logic [17:0]           io_addr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  is_io;
    logic                  wr_cycle;
    logic                  rd_cycle;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  halt_set;
    logic                  unused_addr_bits;

    assign io_addr  = bus.mem_addr[17:0];
    assign ram_idx  = bus.mem_addr[ADDR_WIDTH-1:0];
    assign is_io    = (bus.mem_addr[17:16] == 2'b11);
    assign wr_cycle = bus.rdy & bus.mem_wr;
    assign rd_cycle = bus.rdy & ~bus.mem_wr;

    // Upper address bits are deliberately ignored by the decoder.
    assign unused_addr_bits = ^bus.mem_addr[31:18];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
    assign pop      = (count_q != '0) & bus.tx_ready;
    assign push_req = wr_cycle & is_io & (io_addr == IO_TX_ADDR);
    assign push     = push_req & ((count_q != DEPTH_C) | pop);
    assign halt_set = wr_cycle & is_io & (io_addr == IO_STAT_ADDR);

`ifdef IO_OVERFLOW_EN
    logic ovf_q;
    logic ovf_set;
    logic ovf_clr;

    assign ovf_set = push_req & ~push;
    assign ovf_clr = wr_cycle & is_io & (io_addr == IO_OVF_ADDR);

    // Sticky record of a dropped TX byte; cleared by any write to its I/O slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.io_overflow = ovf_q;
`endif

    // Next FIFO occupancy and pointers; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Read byte selection: RAM contents or the I/O status registers.
    always_comb begin
        rd_data = 8'h00;
        if (is_io) begin
            if (io_addr == IO_STAT_ADDR) begin
                rd_data = 8'(count_q);
            end
`ifdef IO_OVERFLOW_EN
            else if (io_addr == IO_OVF_ADDR) begin
                rd_data = {7'b0, ovf_q};
            end
`endif
        end else begin
            rd_data = ram[ram_idx];
        end
    end

    // Control state: FIFO bookkeeping, registered read byte and sticky halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_dout_q <= 8'h00;
            halt_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (rd_cycle) begin
                mem_dout_q <= rd_data;
            end
            if (halt_set) begin
                halt_q <= 1'b1;
            end
        end
    end

    // RAM write port; contents survive reset, but no write lands while it is held.
    always_ff @(posedge clk) begin
        if (!rst && wr_cycle && !is_io) begin
            ram[ram_idx] <= bus.mem_din;
        end
    end

    // FIFO storage write; accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_buf[wr_ptr_q] <= bus.mem_din;
        end
    end

    assign bus.mem_dout       = mem_dout_q;
    assign bus.tx_valid       = (count_q != '0);
    assign bus.tx_data        = fifo_buf[rd_ptr_q];
    assign bus.io_buffer_full = (count_q >= NEAR_FULL_C);
    assign bus.halt           = halt_q;
endmodule
